pattern_buffer_loader: RTL

//  Serial master that loads one pattern buffer in the buffers block over its serial port.
//  - The buffers block is the slave: ports sclk, sin, sout, ssel, saddr.
//  - A host streams BUFFER_SIZE words through a valid/ready handshake.
//  - This block frames them with ssel, drives saddr, generates sclk from clk and shifts data out MSB-first.
//  - It sits between the configuration/host logic and the buffers block.

---
 rtl/pattern_buffer_loader.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/pattern_buffer_loader.sv
// pattern_buffer_loader: serial master framing one pattern-buffer load (ssel/saddr/sclk/sin).
// Optional `PAT_READBACK_EN captures sout into rd_data/rd_valid.
module pattern_buffer_loader #(
  parameter int BUFFER_SIZE  = 32,
  parameter int BUFFER_WIDTH = 8,
  parameter int CLK_DIV      = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [2:0]              addr,
  output logic                    busy,
  output logic                    done,
  input  logic [BUFFER_WIDTH-1:0] wr_data,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  output logic                    sclk,
  output logic                    sin,
  output logic                    ssel,
  output logic [2:0]              saddr,
  input  logic                    sout,
  output logic [BUFFER_WIDTH-1:0] rd_data,
  output logic                    rd_valid
);

  localparam int BW = (BUFFER_WIDTH > 1) ? $clog2(BUFFER_WIDTH) : 1;
  localparam int WW = (BUFFER_SIZE > 1) ? $clog2(BUFFER_SIZE) : 1;
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [BW-1:0] BIT_LAST  = BW'(BUFFER_WIDTH - 1);
  localparam logic [WW-1:0] WORD_LAST = WW'(BUFFER_SIZE - 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    WAIT_WORD,
    SHIFT_LO,
    SHIFT_HI,
    HOLD
  } state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [BW-1:0]           bit_q, bit_d;
  logic [WW-1:0]           word_q, word_d;
  logic [BUFFER_WIDTH-1:0] shreg_q, shreg_d;
  logic                    sin_q, sin_d;
  logic [2:0]              saddr_q, saddr_d;
  logic                    done_q, done_d;
  logic                    sclk_q, sclk_d;
  logic                    ssel_q, ssel_d;
  logic                    busy_q, busy_d;
  logic                    cnt_last;

  assign cnt_last = (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    word_d  = word_q;
    shreg_d = shreg_q;
    sin_d   = sin_q;
    saddr_d = saddr_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SETUP;
          saddr_d = addr;
          cnt_d   = '0;
          bit_d   = '0;
          word_d  = '0;
        end
      end
      SETUP: begin
        if (cnt_last) begin
          state_d = WAIT_WORD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_WORD: begin
        if (wr_valid) begin
          shreg_d = wr_data;
          sin_d   = wr_data[BUFFER_WIDTH-1];
          bit_d   = '0;
          cnt_d   = '0;
          state_d = SHIFT_LO;
        end
      end
      SHIFT_LO: begin
        if (cnt_last) begin
          state_d = SHIFT_HI;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SHIFT_HI: begin
        if (cnt_last) begin
          cnt_d = '0;
          // next bit is presented on the same edge sclk falls
          if (bit_q != BIT_LAST) begin
            bit_d   = bit_q + 1'b1;
            shreg_d = shreg_q << 1;
            sin_d   = shreg_d[BUFFER_WIDTH-1];
            state_d = SHIFT_LO;
          end else if (word_q != WORD_LAST) begin
            word_d  = word_q + 1'b1;
            state_d = WAIT_WORD;
          end else begin
            state_d = HOLD;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HOLD: begin
        if (cnt_last) begin
          state_d = IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    sclk_d = (state_d == SHIFT_HI);
    ssel_d = (state_d != IDLE);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      word_q  <= '0;
      shreg_q <= '0;
      sin_q   <= 1'b0;
      saddr_q <= '0;
      done_q  <= 1'b0;
      sclk_q  <= 1'b0;
      ssel_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      word_q  <= word_d;
      shreg_q <= shreg_d;
      sin_q   <= sin_d;
      saddr_q <= saddr_d;
      done_q  <= done_d;
      sclk_q  <= sclk_d;
      ssel_q  <= ssel_d;
      busy_q  <= busy_d;
    end
  end

  assign wr_ready = (state_q == WAIT_WORD);
  assign sclk     = sclk_q;
  assign sin      = sin_q;
  assign ssel     = ssel_q;
  assign saddr    = saddr_q;
  assign busy     = busy_q;
  assign done     = done_q;

`ifdef PAT_READBACK_EN
  logic [BUFFER_WIDTH-1:0] cap_q, cap_d;
  logic [BUFFER_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                    rd_valid_q, rd_valid_d;

  // sout sampled in the final cycle of each high phase
  always_comb begin
    cap_d      = cap_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    if (state_q == SHIFT_HI && cnt_last) begin
      cap_d = {cap_q[BUFFER_WIDTH-2:0], sout};
      if (bit_q == BIT_LAST) begin
        rd_data_d  = cap_d;
        rd_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cap_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      cap_q      <= cap_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
`else
  logic sout_unused;
  assign sout_unused = sout;
  assign rd_data     = '0;
  assign rd_valid    = 1'b0;
`endif

endmodule
